riscv_crypto_aes_sbox_pipe: RTL and testbench
=============================================

RISCV_CRYPTO_AES_SBOX_PIPE -- requirements
Module: riscv_crypto_aes_sbox_pipe

Interface
REQ-001 Parameters: LANES, default 4, number of parallel byte S-box lanes (legal 1..8).
REQ-002 Parameters: REG_MID, default 1, 1 = extra register between nonlinear middle layer and output layer, 0 = none.
REQ-003 Ports: clk  in  1  single clock, all state rising-edge.
REQ-004 Ports: reset_n  in  1  asynchronous active-low reset.
REQ-005 Ports: flush  in  1  synchronous pipeline kill.
REQ-006 Ports: in_valid  in  1  input beat offered.
REQ-007 Ports: in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-008 Ports: in_inv  in  1  0 = forward AES S-box, 1 = inverse AES S-box, per beat.
REQ-009 Ports: in_mask  in  LANES  per-lane enable, sampled with the beat.
REQ-010 Ports: in_data  in  8*LANES  input bytes, lane i = bits [8i+7:8i].
REQ-011 Ports: out_valid  out  1  result beat present.
REQ-012 Ports: out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-013 Ports: out_data  out  8*LANES  substituted bytes, lane order as input.

Function
REQ-014 Per lane, datapath = top layer (fwd: 8->21 AES top; inv: 8->21 inverse-AES top) -> shared 21->18 middle layer -> output layer (fwd or inverse 18->8), selected by the beat's in_inv.
REQ-015 Stage S1 registers the 21-bit top-layer result per lane plus inv flag and mask; optional stage SM (REG_MID=1) registers the 18-bit middle result plus inv and mask; stage SO registers final bytes.
REQ-016 Latency from accepted beat to out_valid = 2 + REG_MID cycles with out_ready held high.
REQ-017 Throughput: one beat per cycle sustained when out_ready is continuously high.
REQ-018 Each stage has a valid bit; a stage loads when it is empty or its contents advance in the same cycle.
REQ-019 in_ready = !S1.valid || S1 advancing this cycle; in_ready is combinational from stage valids and out_ready only, never from in_valid.
REQ-020 Backpressure: with out_ready low and all stages full, no stage changes and out_data/out_valid hold stable.
REQ-021 Bubbles collapse: an empty stage accepts from its predecessor regardless of out_ready.
REQ-022 Lanes with mask bit 0 output 0x00; their top-layer registers are not updated (hold previous value) to save toggling.
REQ-023 The inv flag travels with its beat; consecutive beats of mixed mode process correctly with no dead cycle.
REQ-024 flush clears every stage valid on the next edge; a beat offered in the flush cycle is dropped; in_ready is 1 the cycle after flush.
REQ-025 out_data is driven only from SO registers (no combinational path from in_data to out_data).
REQ-026 Data registers need no reset; valid bits must.

Reset
REQ-027 While reset_n is low: all stage valids 0, out_valid 0, out_data 0, in_ready 1 on the first edge after release.
REQ-028 Reset asserted mid-operation discards all in-flight beats immediately (asynchronously); no partial beat emerges after release.

Verification
REQ-029 LANES=4, REG_MID=1, in_inv=0, in_mask=4'hF, in_data=32'h53_01_00_FF, out_ready=1 -> out_data=32'hED_7C_63_16 exactly 3 cycles later.
REQ-030 Same config, in_inv=1, in_data=32'hED_7C_63_16 -> out_data=32'h53_01_00_FF after 3 cycles; back-to-back fwd then inv beats produce both results on consecutive cycles.
REQ-031 in_mask=4'b0101, in_inv=0, in_data=32'h00_00_00_00 -> out_data=32'h00_63_00_63.
REQ-032 Fill pipeline with 3 beats, hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable at the first beat; release -> beats emerge in order, none lost or duplicated.
REQ-033 Assert flush with 2 beats in flight -> out_valid 0 next cycle; subsequent beat 0x53 (fwd) -> 0xED with normal latency.
REQ-034 REG_MID=0, LANES=1: exhaustive 256 fwd and 256 inv bytes against the AES tables, latency 2; inv(fwd(x))=x for all x.

Source files
------------

// File: rtl/riscv_crypto_aes_sbox_pipe.sv
// ----------------------------------------------------------------------------
// riscv_crypto_aes_sbox_pipe
//
// Pipelined multi-lane AES S-box supporting both the forward and the inverse
// substitution. Each lane splits the S-box into three layers:
//   top    : 8 -> 21 linear layer (forward, or inverse affine followed by the
//            forward basis change for the inverse S-box)
//   middle : 21 -> 18 shared nonlinear GF(2^8) inversion core
//   output : 18 -> 8 linear layer (forward affine, or that result passed back
//            through the inverse affine for the inverse S-box)
// Stages: S1 (top result), optional SM (middle result, REG_MID=1), SO (bytes).
// Every stage has a valid bit and loads whenever it is empty or draining.
//
// Ports
//   clk        : clock, all state on the rising edge
//   reset_n    : asynchronous active-low reset
//   flush      : synchronous kill of every in-flight beat
//   in_valid   : input beat offered
//   in_ready   : input beat accepted when in_valid && in_ready
//   in_inv     : 0 = forward S-box, 1 = inverse S-box (per beat)
//   in_mask    : per-lane enable; disabled lanes produce 0x00
//   in_data    : input bytes, lane i = bits [8i+7:8i]
//   out_valid  : result beat present
//   out_ready  : consumer accepts when out_valid && out_ready
//   out_data   : substituted bytes, same lane order as in_data
// ----------------------------------------------------------------------------
module riscv_crypto_aes_sbox_pipe #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned REG_MID = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [LANES-1:0]     in_mask,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data
);

    // Inverse of the AES affine map, constant included.
    function automatic logic [7:0] f_aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Forward top linear layer; u0 is the byte MSB.
    function automatic logic [20:0] f_top_fwd(input logic [7:0] x);
        logic u0, u1, u2, u3, u4, u5, u6, u7;
        logic t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14;
        logic t15, t16, t17, t18, t19, t20, t21, t22, t23, t24, t26, t27;
        {u0, u1, u2, u3, u4, u5, u6, u7} = x;
        t1  = u0 ^ u3;   t2  = u0 ^ u5;   t3  = u0 ^ u6;   t4  = u3 ^ u5;
        t5  = u4 ^ u6;   t6  = t1 ^ t5;   t7  = u1 ^ u2;   t8  = u7 ^ t6;
        t9  = u7 ^ t7;   t10 = t6 ^ t7;   t11 = u1 ^ u5;   t12 = u2 ^ u5;
        t13 = t3 ^ t4;   t14 = t6 ^ t11;  t15 = t5 ^ t11;  t16 = t5 ^ t12;
        t17 = t9 ^ t16;  t18 = u3 ^ u7;   t19 = t7 ^ t18;  t20 = t1 ^ t19;
        t21 = u6 ^ u7;   t22 = t7 ^ t21;  t23 = t2 ^ t22;  t24 = t2 ^ t10;
        t26 = t3 ^ t16;  t27 = t1 ^ t12;
        return {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19, t20,
                t22, t23, t24, t26, t27, u7};
    endfunction

    function automatic logic [20:0] f_top_inv(input logic [7:0] x);
        return f_top_fwd(f_aff_inv(x));
    endfunction

    // Shared nonlinear core. t25 is rebuilt here so the top layer stays 21 wide.
    function automatic logic [17:0] f_mid(input logic [20:0] t);
        logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19, t20;
        logic t22, t23, t24, t25, t26, t27, d;
        logic m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14, m15;
        logic m16, m17, m18, m19, m20, m21, m22, m23, m24, m25, m26, m27, m28;
        logic m29, m30, m31, m32, m33, m34, m35, m36, m37, m38, m39, m40, m41;
        logic m42, m43, m44, m45;
        {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19, t20,
         t22, t23, t24, t26, t27, d} = t;
        t25 = t20 ^ t17;
        m1  = t13 & t6;   m2  = t23 & t8;   m3  = t14 ^ m1;   m4  = t19 & d;
        m5  = m4 ^ m1;    m6  = t3 & t16;   m7  = t22 & t9;   m8  = t26 ^ m6;
        m9  = t20 & t17;  m10 = m9 ^ m6;    m11 = t1 & t15;   m12 = t4 & t27;
        m13 = m12 ^ m11;  m14 = t2 & t10;   m15 = m14 ^ m11;  m16 = m3 ^ m2;
        m17 = m5 ^ t24;   m18 = m8 ^ m7;    m19 = m10 ^ m15;  m20 = m16 ^ m13;
        m21 = m17 ^ m15;  m22 = m18 ^ m13;  m23 = m19 ^ t25;  m24 = m22 ^ m23;
        m25 = m22 & m20;  m26 = m21 ^ m25;  m27 = m20 ^ m21;  m28 = m23 ^ m25;
        m29 = m28 & m27;  m30 = m26 & m24;  m31 = m20 & m23;  m32 = m27 & m31;
        m33 = m27 ^ m25;  m34 = m21 & m22;  m35 = m24 & m34;  m36 = m24 ^ m25;
        m37 = m21 ^ m29;  m38 = m32 ^ m33;  m39 = m23 ^ m30;  m40 = m35 ^ m36;
        m41 = m38 ^ m40;  m42 = m37 ^ m39;  m43 = m37 ^ m38;  m44 = m39 ^ m40;
        m45 = m42 ^ m41;
        return {m44 & t6,  m40 & t8,  m39 & d,   m43 & t16, m38 & t9,  m37 & t17,
                m42 & t15, m45 & t27, m41 & t10, m44 & t13, m40 & t23, m39 & t19,
                m43 & t3,  m38 & t22, m37 & t20, m42 & t1,  m45 & t4,  m41 & t2};
    endfunction

    // Forward output linear layer, AES affine folded in.
    function automatic logic [7:0] f_out_fwd(input logic [17:0] m);
        logic m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58;
        logic m59, m60, m61, m62, m63;
        logic l0, l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, l11, l12, l13, l14;
        logic l15, l16, l17, l18, l19, l20, l21, l22, l23, l24, l25, l26, l27;
        logic l28, l29;
        {m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58, m59,
         m60, m61, m62, m63} = m;
        l0  = m61 ^ m62;  l1  = m50 ^ m56;  l2  = m46 ^ m48;  l3  = m47 ^ m55;
        l4  = m54 ^ m58;  l5  = m49 ^ m61;  l6  = m62 ^ l5;   l7  = m46 ^ l3;
        l8  = m51 ^ m59;  l9  = m52 ^ m53;  l10 = m53 ^ l4;   l11 = m60 ^ l2;
        l12 = m48 ^ m51;  l13 = m50 ^ l0;   l14 = m52 ^ m61;  l15 = m55 ^ l1;
        l16 = m56 ^ l0;   l17 = m57 ^ l1;   l18 = m58 ^ l8;   l19 = m63 ^ l4;
        l20 = l0 ^ l1;    l21 = l1 ^ l7;    l22 = l3 ^ l12;   l23 = l18 ^ l2;
        l24 = l15 ^ l9;   l25 = l6 ^ l10;   l26 = l7 ^ l9;    l27 = l8 ^ l10;
        l28 = l11 ^ l14;  l29 = l11 ^ l17;
        return {l6 ^ l24, ~(l16 ^ l26), ~(l19 ^ l28), l6 ^ l21,
                l20 ^ l22, l25 ^ l29, ~(l13 ^ l27), ~(l6 ^ l23)};
    endfunction

    // Strip the affine back off to leave the bare field inverse.
    function automatic logic [7:0] f_out_inv(input logic [17:0] m);
        return f_aff_inv(f_out_fwd(m));
    endfunction

    logic                    w_s1_ready;
    logic                    w_so_ready;
    logic                    w_pre_valid;
    logic                    w_pre_inv;
    logic [LANES-1:0]        w_pre_mask;
    logic [LANES-1:0][17:0]  w_pre_mid;
    logic [LANES-1:0][20:0]  w_top;
    logic [LANES-1:0][17:0]  w_mid;
    logic [LANES-1:0][7:0]   w_out;

    logic                    r_s1_valid;
    logic                    r_s1_inv;
    logic [LANES-1:0]        r_s1_mask;
    logic [LANES-1:0][20:0]  r_s1_top;
    logic                    r_so_valid;
    logic [8*LANES-1:0]      r_so_data;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] w_sub;
        assign w_top[g] = in_inv ? f_top_inv(in_data[8*g +: 8]) : f_top_fwd(in_data[8*g +: 8]);
        assign w_mid[g] = f_mid(r_s1_top[g]);
        assign w_sub    = w_pre_inv ? f_out_inv(w_pre_mid[g]) : f_out_fwd(w_pre_mid[g]);
        assign w_out[g] = w_pre_mask[g] ? w_sub : 8'h00;
    end

    assign w_so_ready = !r_so_valid || out_ready;
    assign in_ready   = w_s1_ready;

    // S1: top-layer result. Disabled lanes keep their old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && w_s1_ready) begin
            r_s1_inv  <= in_inv;
            r_s1_mask <= in_mask;
            for (int i = 0; i < int'(LANES); i++) begin
                if (in_mask[i]) begin
                    r_s1_top[i] <= w_top[i];
                end
            end
        end
    end

    if (REG_MID != 0) begin : g_sm
        logic                   r_sm_valid;
        logic                   r_sm_inv;
        logic [LANES-1:0]       r_sm_mask;
        logic [LANES-1:0][17:0] r_sm_mid;
        logic                   w_sm_ready;

        assign w_sm_ready = !r_sm_valid || w_so_ready;
        assign w_s1_ready = !r_s1_valid || w_sm_ready;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sm_valid <= 1'b0;
            end else if (flush) begin
                r_sm_valid <= 1'b0;
            end else if (w_sm_ready) begin
                r_sm_valid <= r_s1_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (r_s1_valid && w_sm_ready) begin
                r_sm_inv  <= r_s1_inv;
                r_sm_mask <= r_s1_mask;
                for (int i = 0; i < int'(LANES); i++) begin
                    if (r_s1_mask[i]) begin
                        r_sm_mid[i] <= w_mid[i];
                    end
                end
            end
        end

        assign w_pre_valid = r_sm_valid;
        assign w_pre_inv   = r_sm_inv;
        assign w_pre_mask  = r_sm_mask;
        assign w_pre_mid   = r_sm_mid;
    end else begin : g_nosm
        assign w_s1_ready  = !r_s1_valid || w_so_ready;
        assign w_pre_valid = r_s1_valid;
        assign w_pre_inv   = r_s1_inv;
        assign w_pre_mask  = r_s1_mask;
        assign w_pre_mid   = w_mid;
    end

    // SO: the only source of out_data; reset so out_data reads 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_so_valid <= 1'b0;
            r_so_data  <= '0;
        end else begin
            if (flush) begin
                r_so_valid <= 1'b0;
            end else if (w_so_ready) begin
                r_so_valid <= w_pre_valid;
            end
            if (w_so_ready && w_pre_valid) begin
                r_so_data <= w_out;
            end
        end
    end

    assign out_valid = r_so_valid;
    assign out_data  = r_so_data;

endmodule

// File: tb/tb_riscv_crypto_aes_sbox_pipe.sv
// ----------------------------------------------------------------------------
// Bench for riscv_crypto_aes_sbox_pipe: a 4-lane REG_MID=1 instance driven by
// directed vectors and hand sequences, and a 1-lane REG_MID=0 instance checked
// exhaustively against an AES reference built from GF(2^8) arithmetic.
// ----------------------------------------------------------------------------
module tb_riscv_crypto_aes_sbox_pipe;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        flush, in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [3:0]  in_mask;
    logic [31:0] in_data, out_data;

    logic        d1_flush, d1_in_valid, d1_in_ready, d1_in_inv, d1_out_valid, d1_out_ready;
    logic [0:0]  d1_in_mask;
    logic [7:0]  d1_in_data, d1_out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fwd_tab [256];

    typedef struct packed {
        logic        inv;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    riscv_crypto_aes_sbox_pipe #(.LANES(4), .REG_MID(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_mask(in_mask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    riscv_crypto_aes_sbox_pipe #(.LANES(1), .REG_MID(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_inv(d1_in_inv),
        .in_mask(d1_in_mask), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Reference S-box: x^254 then the AES affine map.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic inv, input logic [3:0] m, input logic [31:0] d);
        in_valid = v;
        in_inv   = inv;
        in_mask  = m;
        in_data  = d;
    endtask

    // Offer one beat at a negedge and count cycles until out_valid rises.
    task automatic lat_check(input string nm, input logic inv, input logic [3:0] m,
                             input logic [31:0] d, input logic [31:0] exp);
        int cnt;
        cnt = 0;
        drive(1'b1, inv, m, d);
        do begin
            @(negedge clk);
            cnt++;
            in_valid = 1'b0;
        end while (!out_valid && cnt < 20);
        check({nm, "_latency"}, cnt, 3);
        check({nm, "_data"}, out_data, exp);
    endtask

    initial begin
        logic [31:0] beat_a, beat_b, beat_c;

        vecs[0] = '{1'b0, 4'hF, 32'h5301_00FF, 32'hED7C_6316};
        vecs[1] = '{1'b1, 4'hF, 32'hED7C_6316, 32'h5301_00FF};
        vecs[2] = '{1'b0, 4'h5, 32'h0000_0000, 32'h0063_0063};
        vecs[3] = '{1'b0, 4'hF, 32'h0011_2233, 32'h6382_93C3};
        vecs[4] = '{1'b1, 4'hF, 32'h6382_93C3, 32'h0011_2233};
        vecs[5] = '{1'b0, 4'hA, 32'h1234_5678, 32'hC900_B100};
        vecs[6] = '{1'b1, 4'h3, 32'hAAAA_7C63, 32'h0000_0100};

        for (int x = 0; x < 256; x++) fwd_tab[x] = ref_sbox(8'(x));

        reset_n = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0);
        d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_inv = 1'b0;
        d1_in_mask = 1'b1; d1_in_data = 8'h00; d1_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_d1_out_valid", {31'b0, d1_out_valid}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {31'b0, in_ready}, 1);
        check("post_reset_out_valid", {31'b0, out_valid}, 0);

        // Back-to-back table stream: one result per cycle, 3 cycles behind.
        for (int k = 0; k < NV + 3; k++) begin
            if (k >= 3) begin
                check($sformatf("vec%0d_valid", k - 3), {31'b0, out_valid}, 1);
                check($sformatf("vec%0d_data", k - 3), out_data, vecs[k - 3].exp);
            end
            if (k < NV) begin
                check($sformatf("vec%0d_in_ready", k), {31'b0, in_ready}, 1);
                drive(1'b1, vecs[k].inv, vecs[k].mask, vecs[k].data);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_drained", {31'b0, out_valid}, 0);

        lat_check("single_fwd", 1'b0, 4'hF, 32'h5301_00FF, 32'hED7C_6316);
        @(negedge clk);

        // Backpressure: fill three stages, stall five cycles, then drain.
        beat_a = vecs[0].exp; beat_b = vecs[3].exp; beat_c = vecs[5].exp;
        out_ready = 1'b0;
        drive(1'b1, vecs[0].inv, vecs[0].mask, vecs[0].data);
        @(negedge clk);
        drive(1'b1, vecs[3].inv, vecs[3].mask, vecs[3].data);
        @(negedge clk);
        drive(1'b1, vecs[5].inv, vecs[5].mask, vecs[5].data);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF);  // must be refused while full
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_in_ready", c), {31'b0, in_ready}, 0);
            check($sformatf("stall%0d_out_valid", c), {31'b0, out_valid}, 1);
            check($sformatf("stall%0d_out_data", c), out_data, beat_a);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_b_valid", {31'b0, out_valid}, 1);
        check("drain_b_data", out_data, beat_b);
        @(negedge clk);
        check("drain_c_valid", {31'b0, out_valid}, 1);
        check("drain_c_data", out_data, beat_c);
        @(negedge clk);
        check("drain_empty", {31'b0, out_valid}, 0);

        // Flush with two beats in flight, plus a beat offered in the flush cycle.
        drive(1'b1, 1'b0, 4'hF, 32'h0011_2233);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'h6382_93C3);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 32'h5301_00FF);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 0);
        check("flush_in_ready", {31'b0, in_ready}, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("flush_quiet%0d", c), {31'b0, out_valid}, 0);
        end
        lat_check("after_flush", 1'b0, 4'h1, 32'h0000_0053, 32'h0000_00ED);
        @(negedge clk);

        // Asynchronous reset mid-stream.
        drive(1'b1, 1'b0, 4'hF, 32'h5301_00FF);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'hED7C_6316);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'h0011_2233);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_out_valid", {31'b0, out_valid}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", {31'b0, out_valid}, 0);
        check("async_reset_out_data", out_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerelease_in_ready", {31'b0, in_ready}, 1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rerelease_quiet%0d", c), {31'b0, out_valid}, 0);
            @(negedge clk);
        end

        // Single lane, no mid register: all forward bytes then all inverse
        // bytes fed with the forward results, latency 2, fully streamed.
        for (int k = 0; k < 514; k++) begin
            if (k == 1) check("d1_latency_not_early", {31'b0, d1_out_valid}, 0);
            if (k >= 2) begin
                int j;
                logic [7:0] e;
                j = k - 2;
                e = (j < 256) ? fwd_tab[j] : 8'(j - 256);
                check($sformatf("d1_%s_%0d_valid", (j < 256) ? "fwd" : "inv", j & 255),
                      {31'b0, d1_out_valid}, 1);
                check($sformatf("d1_%s_%0d_data", (j < 256) ? "fwd" : "inv", j & 255),
                      {24'b0, d1_out_data}, {24'b0, e});
            end
            if (k < 512) begin
                d1_in_valid = 1'b1;
                d1_in_inv   = (k >= 256);
                d1_in_data  = (k < 256) ? 8'(k) : fwd_tab[k - 256];
            end else begin
                d1_in_valid = 1'b0;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
